// File: rtl/sort4_seq_ctrl_if.sv
// sort4_seq_ctrl_if: bundles the producer-side and consumer-side handshakes of
// the sequential 4-key sorter, together with its status outputs.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge where
// valid and ready are both high. The sender holds valid and data stable until
// that edge. The receiver may raise or lower ready freely.
//
// Signals
//   in_valid   producer offers in_data
//   in_ready   controller can accept a word
//   in_data    unsorted word, slot k = bits [W*k+W-1 : W*k]
//   out_valid  out_data holds a finished result
//   out_ready  consumer accepts out_data
//   out_data   sorted word, slot 3 largest
//   swap_count swaps performed on the current word
//   busy       sort in progress
// Modports: master = producer/consumer side, slave = the controller.
interface sort4_seq_ctrl_if #(
  parameter int W = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [4*W-1:0] out_data;
  logic [2:0]     swap_count;
  logic           busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, swap_count, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, swap_count, busy
  );
endinterface

// File: rtl/sort4_seq_ctrl.sv
// sort4_seq_ctrl: sequential bubble sort of four packed W-bit keys. It uses a
// single compare-and-swap unit that steps through adjacent pairs on the fixed
// schedule k=1,2,3 / 1,2 / 1. The result has the largest key in slot 3.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   bus         sort4_seq_ctrl_if.slave (both handshakes + status)
//   o_dbg_state current FSM state (IDLE=0, SORT=1, DONE=2)
//
// Optional feature: define SORT4_EARLY_EXIT_EN to finish as soon as a pass
// completes with no swaps. Results and swap counts do not change, only latency.
module sort4_seq_ctrl #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst,
  sort4_seq_ctrl_if.slave  bus,
  output logic [1:0]       o_dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SORT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     r_state;
  logic [4*W-1:0] r_work;
  logic [2:0]     r_swaps;
  logic [1:0]     r_pass;
  logic [1:0]     r_k;
`ifdef SORT4_EARLY_EXIT_EN
  logic           r_pass_swapped;  // any swap earlier in the current pass
`endif

  logic [W-1:0]   w_lo;
  logic [W-1:0]   w_hi;
  logic           w_swap;
  logic [4*W-1:0] w_next_work;
  logic           w_last_in_pass;
  logic           w_final;

  // Select the pair (k-1, k). k never leaves 1..3, so default covers k=1.
  always_comb begin
    w_lo = r_work[0 +: W];
    w_hi = r_work[W +: W];
    case (r_k)
      2'd2: begin
        w_lo = r_work[W +: W];
        w_hi = r_work[2*W +: W];
      end
      2'd3: begin
        w_lo = r_work[2*W +: W];
        w_hi = r_work[3*W +: W];
      end
      default: begin
        w_lo = r_work[0 +: W];
        w_hi = r_work[W +: W];
      end
    endcase
  end

  // Strict less-than: equal keys stay where they are.
  assign w_swap = (w_hi < w_lo);

  always_comb begin
    w_next_work = r_work;
    if (w_swap) begin
      case (r_k)
        2'd2: begin
          w_next_work[W +: W]   = w_hi;
          w_next_work[2*W +: W] = w_lo;
        end
        2'd3: begin
          w_next_work[2*W +: W] = w_hi;
          w_next_work[3*W +: W] = w_lo;
        end
        default: begin
          w_next_work[0 +: W] = w_hi;
          w_next_work[W +: W] = w_lo;
        end
      endcase
    end
  end

  // Pass p ends at k = 3-p. The whole sort ends at the end of pass 2.
  assign w_last_in_pass = (r_k == (2'd3 - r_pass));
  assign w_final        = w_last_in_pass && (r_pass == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_work         <= '0;
      r_swaps        <= '0;
      r_pass         <= '0;
      r_k            <= 2'd1;
`ifdef SORT4_EARLY_EXIT_EN
      r_pass_swapped <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_work         <= bus.in_data;
            r_swaps        <= '0;
            r_pass         <= '0;
            r_k            <= 2'd1;
`ifdef SORT4_EARLY_EXIT_EN
            r_pass_swapped <= 1'b0;
`endif
            r_state        <= S_SORT;
          end
        end
        S_SORT: begin
          r_work <= w_next_work;
          if (w_swap) r_swaps <= r_swaps + 3'd1;
          if (w_last_in_pass) begin
`ifdef SORT4_EARLY_EXIT_EN
            r_pass_swapped <= 1'b0;
            // A pass with no swaps means the word is already in order.
            if (w_final || !(r_pass_swapped || w_swap)) begin
`else
            if (w_final) begin
`endif
              r_state <= S_DONE;
            end else begin
              r_pass <= r_pass + 2'd1;
              r_k    <= 2'd1;
            end
          end else begin
            r_k <= r_k + 2'd1;
`ifdef SORT4_EARLY_EXIT_EN
            r_pass_swapped <= r_pass_swapped || w_swap;
`endif
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // in_ready is gated by rst so that no word is taken during a reset cycle.
  assign bus.in_ready   = (r_state == S_IDLE) && !rst;
  assign bus.out_valid  = (r_state == S_DONE);
  assign bus.busy       = (r_state == S_SORT);
  assign bus.out_data   = r_work;
  assign bus.swap_count = r_swaps;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_sort4_seq_ctrl.sv
// Directed bench for sort4_seq_ctrl (W=4).
module tb_sort4_seq_ctrl;
  localparam int W = 4;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_errors;
  int         exp_lat_sorted;

  sort4_seq_ctrl_if #(.W(W)) bus ();

  sort4_seq_ctrl #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_word(input logic [4*W-1:0] data);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Cycles from the acceptance edge until out_valid is observed.
  task automatic wait_out(output int lat, output bit timed_out);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    timed_out = !bus.out_valid;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    end
    tick();
    tick();
    n_checks++;
    if ({bus.out_valid, bus.busy, bus.out_data, bus.swap_count} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: out_valid=%b busy=%b out_data=%h swap_count=%0d want all 0",
               bus.out_valid, bus.busy, bus.out_data, bus.swap_count);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || dbg_state !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_release: in_ready=%b state=%0d want 1/0", bus.in_ready, dbg_state);
    end
  endtask

  task automatic test_reverse();
    int lat; bit to;
    accept_word(16'h1234);
    wait_out(lat, to);
    n_checks++;
    if (to || lat != 6) begin
      n_errors++; $display("FAIL reverse_latency: got %0d (timeout=%b) want 6", lat, to);
    end
    n_checks++;
    if (bus.out_data !== 16'h4321 || bus.swap_count !== 3'd6) begin
      n_errors++;
      $display("FAIL reverse_result: got %h/%0d want 4321/6", bus.out_data, bus.swap_count);
    end
    consume();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reverse_release: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_sorted();
    int lat; bit to;
    accept_word(16'hF731);
    wait_out(lat, to);
    n_checks++;
    if (to || lat != exp_lat_sorted) begin
      n_errors++;
      $display("FAIL sorted_latency: got %0d (timeout=%b) want %0d", lat, to, exp_lat_sorted);
    end
    n_checks++;
    if (bus.out_data !== 16'hF731 || bus.swap_count !== 3'd0) begin
      n_errors++;
      $display("FAIL sorted_result: got %h/%0d want f731/0", bus.out_data, bus.swap_count);
    end
    consume();
  endtask

  task automatic test_duplicates();
    int lat; bit to;
    accept_word(16'h5A5A);
    wait_out(lat, to);
    n_checks++;
    if (to || lat != 6) begin
      n_errors++; $display("FAIL dup_latency: got %0d (timeout=%b) want 6", lat, to);
    end
    n_checks++;
    if (bus.out_data !== 16'hAA55 || bus.swap_count !== 3'd3) begin
      n_errors++;
      $display("FAIL dup_result: got %h/%0d want aa55/3", bus.out_data, bus.swap_count);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    int bad;
    accept_word(16'h1234);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0F0F;
    wait_out(lat, to);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h4321 ||
          bus.swap_count !== 3'd6 || bus.in_ready !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (to || bad != 0) begin
      n_errors++;
      $display("FAIL bp_hold: %0d unstable cycles (timeout=%b), last out_valid=%b out_data=%h swap=%0d in_ready=%b want 1/4321/6/0",
               bad, to, bus.out_valid, bus.out_data, bus.swap_count, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_errors++; $display("FAIL bp_accept_next: busy=%b want 1", bus.busy);
    end
    wait_out(lat, to);
    n_checks++;
    if (to || bus.out_data !== 16'hFF00 || bus.swap_count !== 3'd3) begin
      n_errors++;
      $display("FAIL bp_second_result: got %h/%0d (timeout=%b) want ff00/3", bus.out_data, bus.swap_count, to);
    end
    consume();
  endtask

  task automatic test_reset_mid_sort();
    int lat; bit to;
    int seen;
    accept_word(16'h1234);
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid_in_ready: got %b want 0", bus.in_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.out_data !== 16'h0 || bus.swap_count !== 3'd0) begin
      n_errors++;
      $display("FAIL rst_mid_state: in_ready=%b out_valid=%b busy=%b out_data=%h swap=%0d want 1/0/0/0000/0",
               bus.in_ready, bus.out_valid, bus.busy, bus.out_data, bus.swap_count);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid !== 1'b0) seen++;
      tick();
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++; $display("FAIL rst_mid_no_output: out_valid high %0d cycles want 0", seen);
    end
    accept_word(16'h3142);
    wait_out(lat, to);
    n_checks++;
    if (to || bus.out_data !== 16'h4321 || bus.swap_count !== 3'd3) begin
      n_errors++;
      $display("FAIL rst_mid_next: got %h/%0d (timeout=%b) want 4321/3", bus.out_data, bus.swap_count, to);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat; bit to;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h2143;
    tick();
    bus.in_data   = 16'h8800;
    wait_out(lat, to);
    n_checks++;
    if (to || lat != 6 || bus.out_data !== 16'h4321 || bus.swap_count !== 3'd4) begin
      n_errors++;
      $display("FAIL b2b_first: got %h/%0d lat %0d (timeout=%b) want 4321/4 lat 6",
               bus.out_data, bus.swap_count, lat, to);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_handshake: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_errors++; $display("FAIL b2b_second_accept: busy=%b want 1", bus.busy);
    end
    wait_out(lat, to);
    n_checks++;
    if (to || lat != exp_lat_sorted || bus.out_data !== 16'h8800 || bus.swap_count !== 3'd0) begin
      n_errors++;
      $display("FAIL b2b_second: got %h/%0d lat %0d (timeout=%b) want 8800/0 lat %0d",
               bus.out_data, bus.swap_count, lat, to, exp_lat_sorted);
    end
    tick();
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_drain: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_checks      = 0;
    n_errors      = 0;
`ifdef SORT4_EARLY_EXIT_EN
    exp_lat_sorted = 3;
`else
    exp_lat_sorted = 6;
`endif
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    test_reset();
    test_reverse();
    test_sorted();
    test_duplicates();
    test_backpressure();
    test_reset_mid_sort();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
